btb_arbiter: RTL and testbench
==============================

# btb_arbiter

Arbiter and sequencer for the single-ported branch target buffer. Shares the BTB between fetch-stage lookups and execute-stage target updates. Resolved-branch updates are buffered in a small FIFO so execute never waits on the BTB. Lookups are scheduled ahead of updates, and a starvation counter guarantees that queued updates still drain. Sits between the IF/EX pipeline stages and the BTB's mem-style read/write/resp port.

## Interface
- UPD_DEPTH, 2, update FIFO entries; power of two, ≥2
- STARVE_LIMIT, 4, consecutive lookups granted while an update is pending before an update is forced
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- lookup_req  in  1  fetch lookup request; held with lookup_pc until lookup_resp
- lookup_pc  in  32  PC to look up
- lookup_target  out  32  predicted target; valid only when lookup_resp=1
- lookup_resp  out  1  one-cycle completion pulse
- flush  in  1  pipeline redirect; discards any outstanding lookup result
- upd_valid  in  1  resolved branch update offered
- upd_pc  in  32  branch PC
- upd_target  in  32  resolved target
- upd_ready  out  1  FIFO not full; update accepted when upd_valid&&upd_ready
- btb_read  out  1  BTB read strobe
- btb_write  out  1  BTB write strobe
- btb_address  out  32  BTB address
- btb_wdata  out  32  BTB write data (target)
- btb_rdata  in  32  BTB read data
- btb_resp  in  1  BTB transaction complete

## Operation
- FSM states: IDLE, LOOKUP, UPDATE.
- IDLE, chosen in priority order:
  - FIFO non-empty and (lookup_req=0 or FIFO full or starve_cnt==STARVE_LIMIT) → UPDATE.
  - Otherwise, lookup_req=1 and flush=0 → LOOKUP; capture lookup_pc into addr_q.
  - Otherwise stay in IDLE.
- LOOKUP:
  - btb_read=1, btb_address=addr_q.
  - On btb_resp → IDLE.
  - lookup_resp = btb_resp && !discard && !flush; lookup_target = btb_rdata, passed through combinationally.
- UPDATE:
  - btb_write=1, btb_address=head.pc, btb_wdata=head.target.
  - On btb_resp: pop FIFO, → IDLE.
- Strobes, once asserted, are held with stable address/data until btb_resp. A BTB transaction is never aborted.
- discard: set when flush=1 in LOOKUP; cleared on leaving LOOKUP. flush in IDLE only blocks the lookup grant in that cycle. flush has no effect on the FIFO.
- starve_cnt (width clog2(STARVE_LIMIT)+1):
  - +1 on each completed LOOKUP while the FIFO is non-empty, saturating at STARVE_LIMIT.
  - Cleared on entering UPDATE or whenever the FIFO is empty.
- FIFO:
  - wr_ptr/rd_ptr are clog2(UPD_DEPTH) bits and wrap modulo UPD_DEPTH; count is clog2(UPD_DEPTH)+1 bits.
  - upd_ready = (count != UPD_DEPTH), computed from count only. A pop in the same cycle does not raise upd_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- In IDLE, btb_address=0 and btb_wdata=0.

## Timing
- Reset values: state IDLE; count, pointers, starve_cnt, discard, addr_q all 0. Outputs: btb_read=0, btb_write=0, lookup_resp=0, upd_ready=1, btb_address=0, btb_wdata=0, lookup_target=btb_rdata (don't-care).
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and the FIFO contents are lost. Strobes drop asynchronously.
- Lookup latency: req seen in IDLE at cycle 0 → btb_read=1 from cycle 1 → lookup_resp in the same cycle as btb_resp. Minimum is 2 cycles with a one-cycle BTB.
- At least one IDLE cycle separates back-to-back BTB transactions.
- Update acceptance is zero-latency. An update pushed in cycle 0 is visible as FIFO non-empty from cycle 1.
- No combinational path from upd_valid to upd_ready, or from lookup_req to btb_read.

## Test plan
- Reset, then lookup_req=1, lookup_pc=0x60, BTB responds 1 cycle after the read with rdata 0x80 → btb_read in cycle 1 with address 0x60; lookup_resp=1 and lookup_target=0x80 in cycle 2; state IDLE in cycle 3.
- With lookup_req held high, push updates (0x100→0x140) and (0x200→0x1F0) → after 4 completed lookups, one UPDATE is forced: btb_write, address 0x100, wdata 0x140. Lookups resume afterwards.
- Push 2 updates with lookup idle → upd_ready=0 while full. A third upd_valid is not accepted. The writes occur in FIFO order; upd_ready returns to 1 the cycle after the first pop.
- flush=1 during LOOKUP with btb_resp delayed 3 cycles → btb_read is held until resp, lookup_resp stays 0, and the next lookup is granted normally.
- Assert rst for one cycle mid-UPDATE → btb_write=0 immediately, upd_ready=1, FIFO empty, and no write completes after reset.

Source files
------------

// File: rtl/btb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : btb_arbiter
// Brief    : Shares a single-ported BTB between fetch lookups and buffered
//            execute-stage target updates. Lookups win, but a starvation
//            counter forces a queued update through after a run of lookups.
// Revision : 1.0 - initial release
// ============================================================================
module btb_arbiter #(
  parameter int UPD_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_req,
  input  logic [31:0] lookup_pc,
  output logic [31:0] lookup_target,
  output logic        lookup_resp,
  input  logic        flush,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  output logic        upd_ready,
  output logic        btb_read,
  output logic        btb_write,
  output logic [31:0] btb_address,
  output logic [31:0] btb_wdata,
  input  logic [31:0] btb_rdata,
  input  logic        btb_resp
);

  localparam int c_PTR_W = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(UPD_DEPTH) + 1;
  localparam int c_STV_W = $clog2(STARVE_LIMIT) + 1;
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(UPD_DEPTH);
  localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]        r_fifo_pc  [UPD_DEPTH];
  logic [31:0]        r_fifo_tgt [UPD_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_STV_W-1:0] r_starve;
  logic               r_discard;
  logic [31:0]        r_addr;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_grant_lookup;
  logic w_enter_update;
  logic w_lookup_done;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == c_FULL);
  // Ready comes from the registered count only, so a same-cycle pop never
  // opens the door and upd_valid never feeds back into upd_ready.
  assign upd_ready     = !w_full;
  assign w_push        = upd_valid && upd_ready;
  assign lookup_target = btb_rdata;

  // State register; strobes are decoded from it so reset drops them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state selection and BTB port drive; IDLE drives a quiet bus.
  always_comb begin
    w_state_nxt    = r_state;
    btb_read       = 1'b0;
    btb_write      = 1'b0;
    btb_address    = '0;
    btb_wdata      = '0;
    lookup_resp    = 1'b0;
    w_grant_lookup = 1'b0;
    w_enter_update = 1'b0;
    w_pop          = 1'b0;
    w_lookup_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && (!lookup_req || w_full || (r_starve == c_STV_MAX))) begin
          w_state_nxt    = ST_UPDATE;
          w_enter_update = 1'b1;
        end else if (lookup_req && !flush) begin
          w_state_nxt    = ST_LOOKUP;
          w_grant_lookup = 1'b1;
        end
      end
      ST_LOOKUP: begin
        btb_read    = 1'b1;
        btb_address = r_addr;
        // A flush now or earlier in this transaction kills the result.
        lookup_resp = btb_resp && !r_discard && !flush;
        if (btb_resp) begin
          w_lookup_done = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        btb_write   = 1'b1;
        btb_address = r_fifo_pc[r_rd_ptr];
        btb_wdata   = r_fifo_tgt[r_rd_ptr];
        if (btb_resp) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Update FIFO bookkeeping; pointers wrap naturally since depth is 2^n.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; a push never lands on the head slot while it is in use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]  <= upd_pc;
      r_fifo_tgt[r_wr_ptr] <= upd_target;
    end
  end

  // Lookup address capture, flush tracking and starvation accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_discard <= 1'b0;
      r_starve  <= '0;
    end else begin
      if (w_grant_lookup) r_addr <= lookup_pc;

      if ((r_state == ST_LOOKUP) && !btb_resp) r_discard <= r_discard | flush;
      else                                     r_discard <= 1'b0;

      if (w_enter_update || w_empty)
        r_starve <= '0;
      else if (w_lookup_done && (r_starve != c_STV_MAX))
        r_starve <= r_starve + c_STV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_btb_arbiter
// Brief    : Randomized and directed bench for btb_arbiter with a BTB
//            responder and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_req;
  logic [31:0] lookup_pc;
  logic [31:0] lookup_target;
  logic        lookup_resp;
  logic        flush;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_ready;
  logic        btb_read;
  logic        btb_write;
  logic [31:0] btb_address;
  logic [31:0] btb_wdata;
  logic [31:0] btb_rdata;
  logic        btb_resp;

  always #5 clk = ~clk;

  btb_arbiter #(.UPD_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .lookup_req(lookup_req), .lookup_pc(lookup_pc),
    .lookup_target(lookup_target), .lookup_resp(lookup_resp),
    .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_ready(upd_ready),
    .btb_read(btb_read), .btb_write(btb_write), .btb_address(btb_address),
    .btb_wdata(btb_wdata), .btb_rdata(btb_rdata), .btb_resp(btb_resp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus state ----------------
  logic        s_req = 0, s_flush = 0, s_uv = 0;
  logic [31:0] s_pc = 0, s_upc = 0, s_utgt = 0;
  bit          rand_mode = 0;
  bit          seen_resp = 0, seen_acc = 0;
  int          lat_min = 0, lat_max = 0;

  // ---------------- BTB responder ----------------
  logic [31:0] b_mem [logic [31:0]];
  bit          rsp_pend = 0, rsp_rd = 0;
  logic [31:0] rsp_addr = 0;
  int          rsp_rem = 0;

  // ---------------- reference model ----------------
  typedef enum {T_NONE, T_LOOKUP, T_WRITE} txn_e;
  typedef struct { logic [31:0] pc; logic [31:0] tgt; } upd_t;
  logic [31:0] m_mem [logic [31:0]];
  upd_t        m_q[$];
  txn_e        m_txn = T_NONE;
  logic [31:0] m_addr = 0;
  bit          m_disc = 0;
  int          m_starve = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [31:0] b_read(input logic [31:0] a);
    return b_mem.exists(a) ? b_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] m_read(input logic [31:0] a);
    return m_mem.exists(a) ? m_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] pick_pc();
    logic [31:0] p;
    p = 32'($urandom_range(7, 0)) << 6;
    return p;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_txn = T_NONE;
    m_disc = 0;
    m_starve = 0;
    rsp_pend = 0;
  endtask

  // Fetch holds its request until answered; execute holds an update until taken.
  task automatic gen_random();
    if (seen_resp) s_req = 0;
    if (!s_req && ($urandom_range(2, 0) == 0)) begin s_req = 1; s_pc = pick_pc(); end
    s_flush = ($urandom_range(9, 0) == 0);
    if (s_flush && s_req) s_pc = pick_pc();
    if (seen_acc) s_uv = 0;
    if (!s_uv && ($urandom_range(3, 0) == 0)) begin
      s_uv = 1; s_upc = pick_pc(); s_utgt = $urandom;
    end
  endtask

  // Compare this cycle's outputs against the model, then advance everything.
  task automatic check_cycle();
    logic [31:0] e_addr, e_wdata;
    logic        e_resp;
    int          pre_n;
    bit          push;
    e_addr = 0; e_wdata = 0;
    if (m_txn == T_LOOKUP) e_addr = m_addr;
    if (m_txn == T_WRITE) begin e_addr = m_q[0].pc; e_wdata = m_q[0].tgt; end
    e_resp = (m_txn == T_LOOKUP) && btb_resp && !m_disc && !flush;
    check("btb_read", 32'(btb_read), 32'(m_txn == T_LOOKUP));
    check("btb_write", 32'(btb_write), 32'(m_txn == T_WRITE));
    check("btb_address", btb_address, e_addr);
    if (m_txn != T_LOOKUP) check("btb_wdata", btb_wdata, e_wdata);
    check("lookup_resp", 32'(lookup_resp), 32'(e_resp));
    if (e_resp) check("lookup_target", lookup_target, m_read(m_addr));
    check("upd_ready", 32'(upd_ready), 32'(m_q.size() != DEPTH));

    pre_n = m_q.size();
    push  = upd_valid && (pre_n != DEPTH);
    case (m_txn)
      T_NONE: begin
        if (pre_n > 0 && (!lookup_req || pre_n == DEPTH || m_starve == LIMIT)) begin
          m_txn = T_WRITE; m_starve = 0;
        end else if (lookup_req && !flush) begin
          m_txn = T_LOOKUP; m_addr = lookup_pc; m_disc = 0;
        end
      end
      T_LOOKUP: begin
        if (btb_resp) begin
          if (pre_n > 0 && m_starve < LIMIT) m_starve++;
          m_txn = T_NONE; m_disc = 0;
        end else if (flush) m_disc = 1;
      end
      T_WRITE: begin
        if (btb_resp) begin
          m_mem[m_q[0].pc] = m_q[0].tgt;
          void'(m_q.pop_front());
          m_txn = T_NONE;
        end
      end
      default: m_txn = T_NONE;
    endcase
    if (pre_n == 0) m_starve = 0;
    if (push) m_q.push_back('{pc: upd_pc, tgt: upd_target});

    if (btb_resp) begin
      if (btb_write) b_mem[btb_address] = btb_wdata;
      rsp_pend = 0;
    end else if (!rsp_pend && (btb_read || btb_write)) begin
      rsp_pend = 1; rsp_rd = btb_read; rsp_addr = btb_address;
      rsp_rem  = int'($urandom_range(lat_max, lat_min));
    end
    seen_resp = lookup_resp;
    seen_acc  = push;
  endtask

  // One clock: drive inputs just after the edge, check mid-cycle.
  task automatic step();
    @(posedge clk); #1;
    if (rand_mode) gen_random();
    if (rsp_pend && rsp_rem == 0) begin
      btb_resp = 1; btb_rdata = rsp_rd ? b_read(rsp_addr) : $urandom;
    end else begin
      btb_resp = 0; btb_rdata = $urandom;
      if (rsp_pend) rsp_rem--;
    end
    lookup_req = s_req; lookup_pc = s_pc; flush = s_flush;
    upd_valid = s_uv; upd_pc = s_upc; upd_target = s_utgt;
    #4;
    check_cycle();
  endtask

  task automatic settle(input int n);
    s_req = 0; s_uv = 0; s_flush = 0;
    repeat (n) step();
  endtask

  task automatic starve_case(input logic [31:0] pc, input logic [31:0] tgt);
    int nresp;
    bit found;
    nresp = 0; found = 0;
    s_req = 1; s_pc = 32'h10; s_uv = 1; s_upc = pc; s_utgt = tgt;
    step();
    s_uv = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (btb_write) found = 1;
      else if (lookup_resp) nresp++;
    end
    check("starve_forced", 32'(found), 1);
    check("starve_lookups", 32'(nresp), LIMIT);
    check("starve_addr", btb_address, pc);
    check("starve_wdata", btb_wdata, tgt);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (lookup_resp) found = 1;
    end
    check("starve_resume", 32'(found), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] wr_log[$];
    int          cnt;
    bit          found;

    rst = 1; lookup_req = 0; lookup_pc = 0; flush = 0; upd_valid = 0;
    upd_pc = 0; upd_target = 0; btb_rdata = 0; btb_resp = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_read", 32'(btb_read), 0);
    check("rst_write", 32'(btb_write), 0);
    check("rst_resp", 32'(lookup_resp), 0);
    check("rst_ready", 32'(upd_ready), 1);
    check("rst_addr", btb_address, 0);
    check("rst_wdata", btb_wdata, 0);
    @(posedge clk); #2 rst = 0;
    model_reset();

    // Basic lookup with a one-cycle BTB.
    b_mem[32'h60] = 32'h80; m_mem[32'h60] = 32'h80;
    lat_min = 0; lat_max = 0;
    s_req = 1; s_pc = 32'h60;
    step();
    step();
    check("lk_read_c1", 32'(btb_read), 1);
    check("lk_addr_c1", btb_address, 32'h60);
    step();
    check("lk_resp_c2", 32'(lookup_resp), 1);
    check("lk_target_c2", lookup_target, 32'h80);
    s_req = 0;
    step();
    check("lk_idle_c3", 32'({btb_read, btb_write}), 0);

    // Starvation: lookups held high, updates still get through.
    starve_case(32'h100, 32'h140);
    starve_case(32'h200, 32'h1F0);
    settle(6);

    // Fill the FIFO with no lookups; check ordering and ready behaviour.
    lat_min = 2; lat_max = 2;
    s_uv = 1; s_upc = 32'h300; s_utgt = 32'h3A0; step();
    s_upc = 32'h340; s_utgt = 32'h3E0; step();
    s_upc = 32'h380; s_utgt = 32'h420; step();
    check("full_ready", 32'(upd_ready), 0);
    wr_log.delete();
    for (int i = 0; i < 40 && wr_log.size() < 3; i++) begin
      step();
      if (btb_write && btb_resp) begin
        wr_log.push_back(btb_address);
        if (wr_log.size() == 1) begin
          check("pop_ready_same", 32'(upd_ready), 0);
          step();
          check("pop_ready_next", 32'(upd_ready), 1);
          s_uv = 0;
        end
      end
    end
    check("wr_count", 32'(wr_log.size()), 3);
    if (wr_log.size() == 3) begin
      check("wr_order0", wr_log[0], 32'h300);
      check("wr_order1", wr_log[1], 32'h340);
      check("wr_order2", wr_log[2], 32'h380);
    end
    settle(4);

    // Flush during a slow lookup.
    lat_min = 3; lat_max = 3;
    s_req = 1; s_pc = 32'h60;
    step();
    step();
    s_flush = 1; s_pc = 32'h70;
    step();
    check("fl_read_held", 32'(btb_read), 1);
    s_flush = 0;
    cnt = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (lookup_resp) check("fl_no_resp", 32'(lookup_resp), 0);
      if (btb_read) cnt++;
      if (btb_resp) found = 1;
    end
    check("fl_resp_seen", 32'(found), 1);
    check("fl_read_cycles", 32'(cnt), 3);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (lookup_resp) begin
        found = 1;
        check("fl_next_target", lookup_target, 32'hA5A5_0070);
      end
    end
    check("fl_next_granted", 32'(found), 1);
    settle(8);

    // Reset in the middle of an update.
    s_uv = 1; s_upc = 32'h500; s_utgt = 32'h555;
    step();
    s_uv = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (btb_write) found = 1;
    end
    check("mid_upd_reached", 32'(found), 1);
    #1 rst = 1;
    lookup_req = 0; upd_valid = 0; flush = 0; btb_resp = 0;
    #1;
    check("mid_rst_write", 32'(btb_write), 0);
    check("mid_rst_ready", 32'(upd_ready), 1);
    check("mid_rst_addr", btb_address, 0);
    @(posedge clk); #2 rst = 0;
    model_reset();
    lat_min = 0; lat_max = 0;
    repeat (4) step();
    check("mid_rst_nowrite", 32'(b_mem.exists(32'h500)), 0);
    s_req = 1; s_pc = 32'h500;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (lookup_resp) begin
        found = 1;
        check("mid_rst_target", lookup_target, 32'hA5A5_0500);
      end
    end
    check("mid_rst_lookup", 32'(found), 1);
    settle(4);

    // Random traffic against the model.
    lat_min = 0; lat_max = 3;
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    settle(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
